sd_acq_sched: RTL and testbench

Sequencer for the single-acquisition window datapath. It holds a host-written shadow table of window timing words and replays it into the acquisition coder through the choice/data/load interface. It then fires the acquisition start strobe a programmed number of times, tracking each window via the returned enable, and reports completion or abort to the pulse-program controller.

---
 rtl/sd_acq_sched.sv | 150 +++++++++++++++
 tb/tb_sd_acq_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_acq_sched.sv
// rtl/sd_acq_sched.sv - replays a shadow table into the acquisition coder, then sequences start strobes per window
// Optional watchdog on window open/close: define SD_ACQ_SCHED_TIMEOUT_EN.
module sd_acq_sched #(
  parameter int          NWORDS = 11,
  parameter int          ACQ_PW = 4,
  parameter int          GAP    = 8,
  parameter logic [21:0] TMO    = 22'h3FFFFF
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        host_we,
  input  logic [3:0]  host_addr,
  input  logic [15:0] host_wdata,
  input  logic        seq_start,
  input  logic        seq_abort,
  input  logic [15:0] echo_num,
  input  logic        acq_en,
  output logic [3:0]  sd_sacq_choice,
  output logic [15:0] sd_sacq_data,
  output logic        sd_sacq_load,
  output logic        s_acq1,
  output logic        busy,
  output logic        seq_done,
  output logic [15:0] echo_cnt,
  output logic        host_err,
  output logic        tmo_err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, LGAP, ARM, WOPEN, WCLOSE, GAPW, DONE
  } state_t;

  localparam logic [4:0]  NW       = 5'(NWORDS);
  localparam logic [3:0]  LAST_IDX = 4'(NWORDS - 1);
  localparam logic [15:0] PW_LAST  = 16'(ACQ_PW - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

  state_t      state, state_d;
  logic [3:0]  idx;
  logic [15:0] tbl [16];
  logic [3:0]  choice_q;
  logic [15:0] data_q;
  logic [15:0] num_q;
  logic [15:0] echo_cnt_q;
  logic        host_err_q;
  logic [15:0] cnt;
  logic        acq_s1, acq_s2, acq_s3;
  logic        acq_rise, acq_fall;
  logic        timeout;

  assign acq_rise = acq_s2 & ~acq_s3;
  assign acq_fall = ~acq_s2 & acq_s3;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (seq_start) state_d = LOAD;
      LOAD:   state_d = LGAP;
      LGAP:   state_d = (idx == LAST_IDX) ? ARM : LOAD;
      ARM: begin
        if (num_q == 16'd0)     state_d = DONE;
        else if (cnt == PW_LAST) state_d = WOPEN;
      end
      WOPEN:  if (acq_rise) state_d = WCLOSE;
      WCLOSE: if (acq_fall) state_d = GAPW;
      GAPW:   if (cnt == GAP_LAST) state_d = (echo_cnt_q == num_q) ? DONE : ARM;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Start wins over abort in IDLE because this override only applies once busy.
    if (state != IDLE && (seq_abort || timeout)) state_d = IDLE;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      choice_q   <= '0;
      data_q     <= '0;
      num_q      <= '0;
      echo_cnt_q <= '0;
      host_err_q <= 1'b0;
      cnt        <= '0;
      acq_s1     <= 1'b0;
      acq_s2     <= 1'b0;
      acq_s3     <= 1'b0;
      for (int i = 0; i < 16; i++) tbl[i] <= '0;
    end else begin
      state  <= state_d;
      cnt    <= (state_d != state) ? 16'd0 : cnt + 16'd1;
      acq_s1 <= acq_en;
      acq_s2 <= acq_s1;
      acq_s3 <= acq_s2;
      if (host_we) begin
        if (state != IDLE)                 host_err_q <= 1'b1;
        else if ({1'b0, host_addr} < NW)   tbl[host_addr] <= host_wdata;
      end
      case (state)
        IDLE: if (seq_start) begin
          num_q      <= echo_num;
          echo_cnt_q <= '0;
          host_err_q <= 1'b0;
          idx        <= '0;
        end
        LOAD: begin
          choice_q <= idx;
          data_q   <= tbl[idx];
        end
        LGAP: if (idx != LAST_IDX) idx <= idx + 4'd1;
        WCLOSE: if (state_d == GAPW && echo_cnt_q != 16'hFFFF) echo_cnt_q <= echo_cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

`ifdef SD_ACQ_SCHED_TIMEOUT_EN
  logic [21:0] wdog;
  logic        tmo_err_q;

  assign timeout = (state == WOPEN || state == WCLOSE) && (wdog == TMO - 22'd1);
  assign tmo_err = tmo_err_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wdog      <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      wdog <= (state == WOPEN || state == WCLOSE) ? wdog + 22'd1 : 22'd0;
      if (state == IDLE && seq_start) tmo_err_q <= 1'b0;
      else if (timeout)               tmo_err_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign timeout    = 1'b0;
  assign tmo_err    = 1'b0;
`endif

  // Coder bus shows the live entry during LOAD and holds it afterwards.
  assign sd_sacq_choice = (state == LOAD) ? idx : choice_q;
  assign sd_sacq_data   = (state == LOAD) ? tbl[idx] : data_q;
  assign sd_sacq_load   = (state == LOAD);
  assign s_acq1         = (state == ARM) && (num_q != 16'd0);
  assign busy           = (state != IDLE);
  assign seq_done       = (state == DONE) && !seq_abort;
  assign echo_cnt       = echo_cnt_q;
  assign host_err       = host_err_q;

endmodule

// File: tb/tb_sd_acq_sched.sv
// tb/tb_sd_acq_sched.sv - scoreboard bench for sd_acq_sched with a randomized window responder
module tb_sd_acq_sched;
  localparam int NW = 11;
  localparam int PW = 4;
  localparam int GP = 8;
  localparam int EV_LOAD = 0;
  localparam int EV_STROBE = 1;
  localparam int EV_DONE = 2;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_we = 1'b0;
  logic [3:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        seq_start = 1'b0;
  logic        seq_abort = 1'b0;
  logic [15:0] echo_num = '0;
  logic        acq_en = 1'b0;
  logic [3:0]  sd_sacq_choice;
  logic [15:0] sd_sacq_data;
  logic        sd_sacq_load, s_acq1, busy, seq_done, host_err, tmo_err;
  logic [15:0] echo_cnt;

  sd_acq_sched #(.NWORDS(NW), .ACQ_PW(PW), .GAP(GP), .TMO(22'd100)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .seq_start(seq_start), .seq_abort(seq_abort),
    .echo_num(echo_num), .acq_en(acq_en), .sd_sacq_choice(sd_sacq_choice),
    .sd_sacq_data(sd_sacq_data), .sd_sacq_load(sd_sacq_load), .s_acq1(s_acq1),
    .busy(busy), .seq_done(seq_done), .echo_cnt(echo_cnt), .host_err(host_err),
    .tmo_err(tmo_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { int kind; int a; int b; bit rel_drop; int off; } ev_t;
  ev_t         sb[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, start_cyc = 0, drop_cyc = 0, win_cnt = 0, pw_run = 0;
  bit          resp_en = 1'b1;
  logic [15:0] tbl_m [16];

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic take(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_event: got kind %0d a=%0h b=%0h expected none (t=%0t)", kind, a, b, $time);
      return;
    end
    e = sb.pop_front();
    chk("ev_kind", kind, e.kind);
    chk("ev_a", a, e.a);
    chk("ev_b", b, e.b);
    chk("ev_time", cyc - (e.rel_drop ? drop_cyc : start_cyc), e.off);
  endtask

  // Monitor: every load pulse, strobe and done pulse is matched against the scoreboard.
  always @(negedge clk_sys) begin
    if (!rst_n) pw_run = 0;
    else begin
      if (sd_sacq_load) take(EV_LOAD, sd_sacq_choice, sd_sacq_data);
      if (s_acq1) begin
        if (pw_run == 0) take(EV_STROBE, 0, 0);
        pw_run++;
      end else if (pw_run != 0) begin
        chk("strobe_width", pw_run, PW);
        pw_run = 0;
      end
      if (seq_done) take(EV_DONE, echo_cnt, 0);
    end
  end

  // Acquisition block model: opens a window a short while after each strobe.
  initial forever begin
    @(negedge s_acq1);
    if (resp_en && rst_n) begin
      repeat ($urandom_range(1, 8)) @(posedge clk_sys);
      #1 acq_en = 1'b1;
      win_cnt++;
      repeat ($urandom_range(3, 20)) @(posedge clk_sys);
      #1 acq_en = 1'b0;
      drop_cyc = cyc;
    end
  end

  task automatic wr(input int addr, input logic [15:0] data);
    @(posedge clk_sys); #1;
    host_we = 1'b1; host_addr = 4'(addr); host_wdata = data;
    @(posedge clk_sys); #1;
    host_we = 1'b0;
    if (addr < NW) tbl_m[addr] = data;
  endtask

  // Expected run: NW loads 2 cycles apart, then nstr strobes, then done after the last gap.
  task automatic start(input int n, input bit sim_wr, input int wa, input logic [15:0] wd,
                       input bit sim_abort, input int nstr, input bit dn);
    @(posedge clk_sys); #1;
    seq_start = 1'b1; echo_num = 16'(n); seq_abort = sim_abort;
    if (sim_wr) begin host_we = 1'b1; host_addr = 4'(wa); host_wdata = wd; end
    start_cyc = cyc;
    if (sim_wr && wa < NW) tbl_m[wa] = wd;
    for (int k = 0; k < NW; k++) sb.push_back('{EV_LOAD, k, tbl_m[k], 1'b0, 1 + 2 * k});
    for (int j = 0; j < nstr; j++)
      sb.push_back('{EV_STROBE, 0, 0, (j != 0), (j == 0) ? 1 + 2 * NW : 3 + GP});
    if (dn) sb.push_back('{EV_DONE, n, 0, (n != 0), (n == 0) ? 2 + 2 * NW : 3 + GP});
    @(posedge clk_sys); #1;
    seq_start = 1'b0; seq_abort = 1'b0; host_we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (!busy) break;
    end
    chk("run_finished_busy", busy, 1'b0);
  endtask

  task automatic run(input int n, input bit sim_wr, input int wa, input logic [15:0] wd,
                     input bit sim_abort, input bit busy_wr);
    start(n, sim_wr, wa, wd, sim_abort, n, 1'b1);
    if (busy_wr) begin
      @(posedge clk_sys); #1;
      host_we = 1'b1; host_addr = 4'd2; host_wdata = 16'($urandom);
      @(posedge clk_sys); #1;
      host_we = 1'b0;
      @(negedge clk_sys);
      chk("host_err_set", host_err, 1'b1);
    end
    wait_idle(3000);
    chk("echo_cnt_end", echo_cnt, n);
    chk("sb_empty", sb.size(), 0);
    chk("host_err_end", host_err, busy_wr);
    chk("tmo_err_end", tmo_err, 1'b0);
  endtask

  initial begin
    int base;
    for (int k = 0; k < 16; k++) tbl_m[k] = '0;
    repeat (3) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    @(negedge clk_sys);
    chk("reset_bus", {sd_sacq_choice, sd_sacq_data}, 0);
    chk("reset_flags", {sd_sacq_load, s_acq1, busy, seq_done, host_err, tmo_err}, 0);
    chk("reset_echo_cnt", echo_cnt, 0);

    for (int k = 0; k < NW; k++) wr(k, 16'h1000 + 16'(k));
    run(0, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    run(3, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    run(2, 1'b0, 0, 16'h0, 1'b0, 1'b1);
    run(1, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    for (int a = NW; a < 16; a++) wr(a, 16'($urandom));
    run(0, 1'b1, 4, 16'hBEEF, 1'b1, 1'b0);

    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 3)) wr($urandom_range(0, 15), 16'($urandom));
      run($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 15), 16'($urandom),
          1'($urandom), 1'b0);
    end

    base = win_cnt;
    start(5, 1'b0, 0, 16'h0, 1'b0, 2, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_sys);
      if (win_cnt >= base + 2) break;
    end
    chk("abort_second_window", win_cnt - base, 2);
    #1 seq_abort = 1'b1;
    @(posedge clk_sys); #1 seq_abort = 1'b0;
    @(negedge clk_sys);
    chk("abort_busy", busy, 1'b0);
    chk("abort_strobe_load", {s_acq1, sd_sacq_load}, 0);
    chk("abort_echo_cnt", echo_cnt, 1);
    repeat (60) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("abort_idle_after", {busy, echo_cnt}, {1'b0, 16'd1});
    chk("abort_sb_empty", sb.size(), 0);

    start(1, 1'b0, 0, 16'h0, 1'b0, 1, 1'b1);
    @(posedge clk_sys); #1;
    host_we = 1'b1; host_addr = 4'd2; host_wdata = 16'h5A5A;
    @(posedge clk_sys); #1 host_we = 1'b0;
    @(negedge clk_sys);
    chk("pre_reset_host_err", host_err, 1'b1);
    @(posedge clk_sys);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_bus", {sd_sacq_choice, sd_sacq_data}, 0);
    chk("async_reset_flags", {sd_sacq_load, s_acq1, busy, seq_done, host_err, tmo_err}, 0);
    chk("async_reset_echo_cnt", echo_cnt, 0);
    sb.delete();
    for (int k = 0; k < 16; k++) tbl_m[k] = '0;
    repeat (2) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    run(0, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    run(1, 1'b0, 0, 16'h0, 1'b0, 1'b0);

`ifdef SD_ACQ_SCHED_TIMEOUT_EN
    resp_en = 1'b0;
    start(1, 1'b0, 0, 16'h0, 1'b0, 1, 1'b0);
    wait_idle(3000);
    chk("tmo_err_set", tmo_err, 1'b1);
    chk("tmo_echo_cnt", echo_cnt, 0);
    chk("tmo_sb_empty", sb.size(), 0);
    resp_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got time %0t expected test end earlier", $time);
    $fatal(1, "global timeout");
  end
endmodule
